// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: UART receive handshake plus memory write port of the boot loader.
interface uart_boot_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic                  rx_parity_error;
    logic                  rx_clr;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        input  rx_valid, rx_byte, rx_parity_error,
        output rx_clr, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_valid, rx_byte, rx_parity_error,
        input  rx_clr, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a checksummed little-endian word image from UART into memory, holding the core until verified.
module uart_boot_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                boot_en,
    uart_boot_loader_if.master  bus,
    output logic                core_hold,
    output logic                boot_done,
    output logic                boot_error,
    output logic [15:0]         word_count
);
    localparam logic [2:0] CNT_LO = 3'd0;
    localparam logic [2:0] CNT_HI = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERROR  = 3'd5;
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    logic [2:0]            state;
    logic [7:0]            cnt_lo;
    logic [7:0]            acc;
    logic [1:0]            byte_idx;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [DATA_WIDTH-9:0] shift;
    logic                  accept;
    logic [15:0]           n_full;
    logic                  last_word;

    assign accept = bus.rx_valid && (state == CNT_HI || state == DATA || state == CHECK ||
                                     (state == CNT_LO && boot_en));
    assign n_full = {bus.rx_byte, cnt_lo};
    // word_count is nonzero whenever DATA is reached, so N-1 cannot underflow here
    assign last_word = 16'(word_idx) == word_count - 16'd1;

    assign core_hold  = state != DONE;
    assign boot_done  = state == DONE;
    assign boot_error = state == ERROR;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= CNT_LO;
            cnt_lo        <= '0;
            acc           <= '0;
            byte_idx      <= '0;
            word_idx      <= '0;
            shift         <= '0;
            word_count    <= '0;
            bus.rx_clr    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.rx_clr <= accept;
            bus.mem_we <= 1'b0;
            if (accept) begin
                if (state != CHECK)
                    acc <= acc ^ bus.rx_byte;
                if (bus.rx_parity_error)
                    state <= ERROR;
                else if (state == CNT_LO) begin
                    cnt_lo <= bus.rx_byte;
                    state  <= CNT_HI;
                end else if (state == CNT_HI) begin
                    word_count <= n_full;
                    state      <= n_full == 16'd0 ? CHECK :
                                  {1'b0, n_full} > MAX_WORDS ? ERROR : DATA;
                end else if (state == DATA) begin
                    shift    <= {bus.rx_byte, shift[DATA_WIDTH-9:8]};
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= word_idx;
                        bus.mem_wdata <= {bus.rx_byte, shift};
                        word_idx      <= word_idx + 1'b1;
                        state         <= last_word ? CHECK : DATA;
                    end
                end else
                    state <= bus.rx_byte == acc ? DONE : ERROR;
            end else if (state == CNT_LO && !boot_en)
                state <= DONE;
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed byte streams; expected memory writes are queued and checked by a monitor.
module tb_uart_boot_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        boot_en = 1'b0;
    logic        core_hold, boot_done, boot_error;
    logic [15:0] word_count;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  clr_cnt = 0;

    always #5 clk = ~clk;

    uart_boot_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus();

    uart_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk),
        .rst(rst),
        .boot_en(boot_en),
        .bus(bus),
        .core_hold(core_hold),
        .boot_done(boot_done),
        .boot_error(boot_error),
        .word_count(word_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus.rx_clr)
            clr_cnt++;
        if (rst && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual_addr=%h actual_data=%h required=no_write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("write_data", bus.mem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic par = 1'b0);
        bus.rx_valid        = 1'b1;
        bus.rx_byte         = b;
        bus.rx_parity_error = par;
        tick();
        bus.rx_valid        = 1'b0;
        bus.rx_parity_error = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        tick();
    endtask

    task automatic do_reset(input logic en);
        rst = 1'b0;
        boot_en = en;
        repeat (3) tick();
        chk("reset_core_hold", 32'(core_hold), 32'd1);
        chk("reset_boot_done", 32'(boot_done), 32'd0);
        chk("reset_boot_error", 32'(boot_error), 32'd0);
        chk("reset_word_count", 32'(word_count), 32'd0);
        chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset_rx_clr", 32'(bus.rx_clr), 32'd0);
        clr_cnt = 0;
        rst = 1'b1;
    endtask

    task automatic finish_chk(input string tag, input logic done, input logic err,
                              input logic [15:0] wc, input int clrs);
        repeat (4) tick();
        chk({tag, "_boot_done"}, 32'(boot_done), 32'(done));
        chk({tag, "_boot_error"}, 32'(boot_error), 32'(err));
        chk({tag, "_core_hold"}, 32'(core_hold), 32'(!done));
        chk({tag, "_word_count"}, 32'(word_count), 32'(wc));
        chk({tag, "_rx_clr_count"}, 32'(clr_cnt), 32'(clrs));
        chk({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic stream_deadbeef(input logic [7:0] ck);
        exp_q.push_back('{10'd0, 32'hDEADBEEF});
        send_gap(8'h01); send_gap(8'h00);
        send_gap(8'hEF); send_gap(8'hBE); send_gap(8'hAD); send_gap(8'hDE);
        send_gap(ck);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ck;
        logic [9:0] a;
        bus.rx_valid = 1'b0;
        bus.rx_byte = 8'h00;
        bus.rx_parity_error = 1'b0;

        do_reset(1'b0);
        tick();
        chk("skip_boot_done_cycle1", 32'(boot_done), 32'd1);
        chk("skip_core_hold_cycle1", 32'(core_hold), 32'd0);
        send(8'h55);
        finish_chk("skip", 1'b1, 1'b0, 16'd0, 0);

        do_reset(1'b1);
        stream_deadbeef(8'h23);
        finish_chk("one_word", 1'b1, 1'b0, 16'd1, 7);

        do_reset(1'b1);
        send_gap(8'h00); send_gap(8'h00); send_gap(8'h00);
        finish_chk("empty", 1'b1, 1'b0, 16'd0, 3);

        do_reset(1'b1);
        exp_q.push_back('{10'd0, 32'h04030201});
        exp_q.push_back('{10'd1, 32'h08070605});
        send(8'h02); send(8'h00);
        for (int i = 1; i <= 8; i++) send(8'(i));
        send(8'h0A);
        finish_chk("two_words", 1'b1, 1'b0, 16'd2, 11);

        do_reset(1'b1);
        stream_deadbeef(8'h24);
        send_gap(8'h11); send_gap(8'h22);
        finish_chk("bad_checksum", 1'b0, 1'b1, 16'd1, 7);

        do_reset(1'b1);
        send_gap(8'h01); send_gap(8'h04);
        for (int i = 0; i < 8; i++) send_gap(8'hA0 + 8'(i));
        finish_chk("count_too_big", 1'b0, 1'b1, 16'h0401, 2);

        do_reset(1'b1);
        send_gap(8'h01); send_gap(8'h00); send(8'hEF, 1'b1); tick();
        send_gap(8'hBE); send_gap(8'hAD); send_gap(8'hDE); send_gap(8'h23);
        finish_chk("parity", 1'b0, 1'b1, 16'd1, 3);

        do_reset(1'b1);
        exp_q.push_back('{10'd0, 32'h04030201});
        send(8'h02); send(8'h00);
        for (int i = 1; i <= 5; i++) send(8'(i));
        repeat (2) tick();
        chk("midload_writes_pending", 32'(exp_q.size()), 32'd0);
        do_reset(1'b1);
        stream_deadbeef(8'h23);
        finish_chk("after_reset", 1'b1, 1'b0, 16'd1, 7);

        do_reset(1'b1);
        ck = 8'h04;
        send(8'h00); send(8'h04);
        for (int i = 0; i < 1024; i++) begin
            a = i[9:0];
            exp_q.push_back('{a, {24'h100000, 8'h00} | 32'(a)});
            send(a[7:0]);
            send({6'b0, a[9:8]});
            send(8'h00);
            send(8'h10);
            ck = ck ^ a[7:0] ^ {6'b0, a[9:8]} ^ 8'h10;
        end
        send(ck);
        finish_chk("full_image", 1'b1, 1'b0, 16'd1024, 4099);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
